// File: rtl/sevenseg_scan_decoder_if.sv
// sevenseg_scan_decoder_if
//   Bundles the multiplexed seven-segment bus (an/seg) together with the
//   frame-level results recovered from it.
//   master : drives an/seg (display side or bench), observes the results
//   slave  : the scan decoder, samples an/seg and drives the results
//   an          4   digit enables, active-low, an[0]=digit0 .. an[3]=digit3
//   seg         7   segments, active-low, {g,f,e,d,c,b,a}
//   frame       16  {digit3,digit2,digit1,digit0} of last complete scan
//   frame_valid 1   one-cycle pulse when frame updates
//   frame_count 8   complete frames received, modulo 256
//   seg_err     1   one-cycle pulse, undecodable segment pattern accepted
//   seq_err     1   one-cycle pulse, digit out of order or illegal an
interface sevenseg_scan_decoder_if;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic [15:0] frame;
  logic        frame_valid;
  logic [7:0]  frame_count;
  logic        seg_err;
  logic        seq_err;

  modport master (
    output an, seg,
    input  frame, frame_valid, frame_count, seg_err, seq_err
  );

  modport slave (
    input  an, seg,
    output frame, frame_valid, frame_count, seg_err, seq_err
  );
endinterface

// File: rtl/sevenseg_scan_decoder.sv
// sevenseg_scan_decoder
//   Receive side of a multiplexed 4-digit seven-segment bus. The bus is
//   registered every clock, a digit is accepted once {an,seg} has been
//   stable for STABLE_CYCLES consecutive samples, its segment pattern is
//   decoded back to a hex nibble, and complete digit0->digit3 scans are
//   assembled into a 16-bit frame.
//   clk   in  system clock, rising edge
//   btnC  in  asynchronous active-high reset
//   bus   slave modport: an/seg in; frame, frame_valid, frame_count,
//         seg_err, seq_err out
module sevenseg_scan_decoder #(
  parameter int STABLE_CYCLES = 1
) (
  input  logic clk,
  input  logic btnC,
  sevenseg_scan_decoder_if.slave bus
);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] COLLECT = 1'b1;

  // One bit wider than the largest STABLE_CYCLES so the counter can park
  // just past the accept value and a held input is never re-accepted.
  localparam logic [8:0] STABLE_LEN = 9'(STABLE_CYCLES);

  logic [10:0] s1Reg;
  logic [8:0]  runCount;
  logic [0:0]  stateReg;
  logic [1:0]  expIdx;
  logic [11:0] partialReg;
  logic [15:0] frameReg;
  logic        frameValidReg;
  logic [7:0]  frameCountReg;
  logic        segErrReg;
  logic        seqErrReg;

  logic [3:0]  sAn;
  logic [6:0]  sSeg;
  logic        accept;
  logic        anBlank;
  logic        anValid;
  logic [1:0]  digitIdx;
  logic        segOk;
  logic [3:0]  nibble;

  assign sAn    = s1Reg[10:7];
  assign sSeg   = s1Reg[6:0];
  assign accept = (runCount == STABLE_LEN);

  always_comb begin
    anBlank  = 1'b0;
    anValid  = 1'b1;
    digitIdx = 2'd0;
    case (sAn)
      4'b1110: digitIdx = 2'd0;
      4'b1101: digitIdx = 2'd1;
      4'b1011: digitIdx = 2'd2;
      4'b0111: digitIdx = 2'd3;
      4'b1111: anBlank  = 1'b1;
      default: anValid  = 1'b0;
    endcase
  end

  always_comb begin
    segOk  = 1'b1;
    nibble = 4'h0;
    case (sSeg)
      7'b1000000: nibble = 4'h0;
      7'b1111001: nibble = 4'h1;
      7'b0100100: nibble = 4'h2;
      7'b0110000: nibble = 4'h3;
      7'b0011001: nibble = 4'h4;
      7'b0010010: nibble = 4'h5;
      7'b0000010: nibble = 4'h6;
      7'b1111000: nibble = 4'h7;
      7'b0000000: nibble = 4'h8;
      7'b0010000: nibble = 4'h9;
      7'b0001000: nibble = 4'hA;
      7'b0000011: nibble = 4'hB;
      7'b1000110: nibble = 4'hC;
      7'b0100001: nibble = 4'hD;
      7'b0000110: nibble = 4'hE;
      7'b0001110: nibble = 4'hF;
      default:    segOk  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge btnC) begin
    if (btnC) begin
      s1Reg         <= {4'b1111, 7'b1111111};
      runCount      <= 9'd0;
      stateReg      <= IDLE;
      expIdx        <= 2'd0;
      partialReg    <= 12'h000;
      frameReg      <= 16'h0000;
      frameValidReg <= 1'b0;
      frameCountReg <= 8'd0;
      segErrReg     <= 1'b0;
      seqErrReg     <= 1'b0;
    end else begin
      s1Reg <= {bus.an, bus.seg};
      if ({bus.an, bus.seg} != s1Reg)
        runCount <= 9'd1;
      else if (runCount <= STABLE_LEN)
        runCount <= runCount + 9'd1;

      frameValidReg <= 1'b0;
      segErrReg     <= 1'b0;
      seqErrReg     <= 1'b0;

      // Blank scans are invisible: no flag and the collection state is kept.
      if (accept && !anBlank) begin
        if (!anValid) begin
          seqErrReg <= 1'b1;
          stateReg  <= IDLE;
        end else if (!segOk) begin
          segErrReg <= 1'b1;
          stateReg  <= IDLE;
        end else begin
          case (stateReg)
            IDLE: begin
              if (digitIdx == 2'd0) begin
                partialReg[3:0] <= nibble;
                expIdx          <= 2'd1;
                stateReg        <= COLLECT;
              end
            end
            default: begin
              if (digitIdx == 2'd0) begin
                // A fresh digit0 always restarts the scan.
                partialReg[3:0] <= nibble;
                expIdx          <= 2'd1;
              end else if (digitIdx == expIdx && expIdx != 2'd3) begin
                if (expIdx == 2'd1)
                  partialReg[7:4] <= nibble;
                else
                  partialReg[11:8] <= nibble;
                expIdx <= expIdx + 2'd1;
              end else if (digitIdx == 2'd3 && expIdx == 2'd3) begin
                frameReg      <= {nibble, partialReg};
                frameValidReg <= 1'b1;
                frameCountReg <= frameCountReg + 8'd1;
                stateReg      <= IDLE;
              end else begin
                seqErrReg <= 1'b1;
                stateReg  <= IDLE;
              end
            end
          endcase
        end
      end
    end
  end

  assign bus.frame       = frameReg;
  assign bus.frame_valid = frameValidReg;
  assign bus.frame_count = frameCountReg;
  assign bus.seg_err     = segErrReg;
  assign bus.seq_err     = seqErrReg;

endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
// tb_sevenseg_scan_decoder
//   Two decoders (STABLE_CYCLES=1 and 3) driven by directed scans. The
//   stimulus pushes each expected output event (kind, frame, count, cycle)
//   into a per-instance queue; monitors pop and compare whenever a pulse
//   appears on the matching instance.
module tb_sevenseg_scan_decoder;

  typedef struct {
    logic [2:0]  kind;   // {frame_valid, seg_err, seq_err}
    logic [15:0] frame;
    logic [7:0]  count;
    int          cyc;
  } ev_t;

  localparam logic [2:0] K_NONE  = 3'b000;
  localparam logic [2:0] K_FRAME = 3'b100;
  localparam logic [2:0] K_SEG   = 3'b010;
  localparam logic [2:0] K_SEQ   = 3'b001;

  logic clk = 1'b0;
  logic btnC = 1'b1;
  int   cyc = 0;
  int   passCount = 0;
  int   totalCount = 0;

  ev_t q1[$];
  ev_t q3[$];
  logic [15:0] lastFrame1 = 16'h0;
  logic [15:0] lastFrame3 = 16'h0;
  logic [7:0]  cnt1 = 8'd0;
  logic [7:0]  cnt3 = 8'd0;

  sevenseg_scan_decoder_if bus1();
  sevenseg_scan_decoder_if bus3();

  sevenseg_scan_decoder #(.STABLE_CYCLES(1)) dut1 (.clk(clk), .btnC(btnC), .bus(bus1.slave));
  sevenseg_scan_decoder #(.STABLE_CYCLES(3)) dut3 (.clk(clk), .btnC(btnC), .bus(bus3.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCount++;
    if (act === exp) passCount++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  function automatic logic [3:0] digitAn(input int i);
    case (i)
      0: return 4'b1110;
      1: return 4'b1101;
      2: return 4'b1011;
      default: return 4'b0111;
    endcase
  endfunction

  // Segment patterns for 3,5,8,E -> frame 16'hE853.
  function automatic logic [6:0] digitSeg(input int i);
    case (i)
      0: return 7'b0110000;
      1: return 7'b0010010;
      2: return 7'b0000000;
      default: return 7'b0000110;
    endcase
  endfunction

  // Drive one bus value for a number of cycles; optionally queue the event
  // it must produce. Value set after edge K lands in s1 at K+1 and its
  // result is registered at K+1+STABLE_CYCLES.
  task automatic hold(input int sel, input logic [3:0] an, input logic [6:0] seg, input int cycles,
                      input logic [2:0] kind, input logic [15:0] fr, input logic [7:0] cnt);
    ev_t e;
    if (sel == 0) begin
      bus1.an = an; bus1.seg = seg;
    end else begin
      bus3.an = an; bus3.seg = seg;
    end
    if (kind != K_NONE) begin
      e.kind = kind; e.frame = fr; e.count = cnt;
      e.cyc = cyc + 1 + ((sel == 0) ? 1 : 3);
      if (sel == 0) q1.push_back(e); else q3.push_back(e);
    end
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic scan(input int sel, input int cycles, input bit blanks);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        if (sel == 0) begin
          cnt1 = cnt1 + 8'd1; lastFrame1 = 16'hE853;
          hold(sel, digitAn(i), digitSeg(i), cycles, K_FRAME, lastFrame1, cnt1);
        end else begin
          cnt3 = cnt3 + 8'd1; lastFrame3 = 16'hE853;
          hold(sel, digitAn(i), digitSeg(i), cycles, K_FRAME, lastFrame3, cnt3);
        end
      end else begin
        hold(sel, digitAn(i), digitSeg(i), cycles, K_NONE, 16'h0, 8'h0);
      end
      if (blanks) hold(sel, 4'b1111, 7'b1111111, cycles, K_NONE, 16'h0, 8'h0);
    end
    hold(sel, 4'b1111, 7'b1111111, cycles, K_NONE, 16'h0, 8'h0);
  endtask

  task automatic monitorEvent(input int sel, input logic [2:0] k, input logic [15:0] fr, input logic [7:0] c);
    ev_t e;
    string tag;
    tag = (sel == 0) ? "s1" : "s3";
    if ((sel == 0 && q1.size() == 0) || (sel != 0 && q3.size() == 0)) begin
      checkVal({tag, "_unexpected_event"}, {29'd0, k}, 32'd0);
    end else begin
      if (sel == 0) e = q1.pop_front(); else e = q3.pop_front();
      checkVal({tag, "_event_kind"}, {29'd0, k}, {29'd0, e.kind});
      checkVal({tag, "_event_frame"}, {16'd0, fr}, {16'd0, e.frame});
      checkVal({tag, "_event_count"}, {24'd0, c}, {24'd0, e.count});
      checkVal({tag, "_event_cycle"}, cyc, e.cyc);
      $display("event %s kind=%b frame=%h count=%0d cycle=%0d", tag, k, fr, c, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (bus1.frame_valid || bus1.seg_err || bus1.seq_err)
      monitorEvent(0, {bus1.frame_valid, bus1.seg_err, bus1.seq_err}, bus1.frame, bus1.frame_count);
  end

  always @(negedge clk) begin
    if (bus3.frame_valid || bus3.seg_err || bus3.seq_err)
      monitorEvent(1, {bus3.frame_valid, bus3.seg_err, bus3.seq_err}, bus3.frame, bus3.frame_count);
  end

  initial begin
    bus1.an = 4'b1111; bus1.seg = 7'b1111111;
    bus3.an = 4'b1111; bus3.seg = 7'b1111111;
    repeat (3) @(posedge clk);
    #1;
    checkVal("reset_frame1", {16'd0, bus1.frame}, 32'd0);
    checkVal("reset_count1", {24'd0, bus1.frame_count}, 32'd0);
    checkVal("reset_flags1", {29'd0, bus1.frame_valid, bus1.seg_err, bus1.seq_err}, 32'd0);
    checkVal("reset_frame3", {16'd0, bus3.frame}, 32'd0);
    btnC = 1'b0;
    hold(0, 4'b1111, 7'b1111111, 2, K_NONE, 16'h0, 8'h0);

    // Clean scan, 2 clocks per digit.
    scan(0, 2, 1'b0);
    checkVal("t1_frame_held", {16'd0, bus1.frame}, 32'hE853);

    // Undecodable digit1 aborts the scan; digits 2,3 are then ignored.
    hold(0, digitAn(0), digitSeg(0), 2, K_NONE, 16'h0, 8'h0);
    hold(0, digitAn(1), 7'b1111111, 2, K_SEG, lastFrame1, cnt1);
    hold(0, digitAn(2), digitSeg(2), 2, K_NONE, 16'h0, 8'h0);
    hold(0, digitAn(3), digitSeg(3), 2, K_NONE, 16'h0, 8'h0);
    hold(0, 4'b1111, 7'b1111111, 2, K_NONE, 16'h0, 8'h0);
    scan(0, 2, 1'b0);

    // Skipped digit1 -> sequence error, frame unchanged.
    hold(0, digitAn(0), digitSeg(0), 2, K_NONE, 16'h0, 8'h0);
    hold(0, digitAn(2), digitSeg(2), 2, K_SEQ, lastFrame1, cnt1);
    hold(0, 4'b1111, 7'b1111111, 2, K_NONE, 16'h0, 8'h0);

    // STABLE_CYCLES=3: digit1 held only 2 clocks never counts.
    hold(1, digitAn(0), digitSeg(0), 3, K_NONE, 16'h0, 8'h0);
    hold(1, digitAn(1), digitSeg(1), 2, K_NONE, 16'h0, 8'h0);
    hold(1, digitAn(2), digitSeg(2), 3, K_SEQ, lastFrame3, cnt3);
    hold(1, 4'b1111, 7'b1111111, 3, K_NONE, 16'h0, 8'h0);
    scan(1, 3, 1'b0);

    // Reset mid-frame after digits 0,1.
    hold(0, digitAn(0), digitSeg(0), 2, K_NONE, 16'h0, 8'h0);
    hold(0, digitAn(1), digitSeg(1), 2, K_NONE, 16'h0, 8'h0);
    btnC = 1'b1;
    #1;
    checkVal("t5_reset_frame1", {16'd0, bus1.frame}, 32'd0);
    checkVal("t5_reset_count1", {24'd0, bus1.frame_count}, 32'd0);
    checkVal("t5_reset_count3", {24'd0, bus3.frame_count}, 32'd0);
    cnt1 = 8'd0; lastFrame1 = 16'h0;
    cnt3 = 8'd0; lastFrame3 = 16'h0;
    @(posedge clk);
    #1;
    btnC = 1'b0;
    hold(0, digitAn(2), digitSeg(2), 2, K_NONE, 16'h0, 8'h0);
    hold(0, digitAn(3), digitSeg(3), 2, K_NONE, 16'h0, 8'h0);
    hold(0, 4'b1111, 7'b1111111, 2, K_NONE, 16'h0, 8'h0);
    checkVal("t5_no_frame", {16'd0, bus1.frame}, 32'd0);

    // Blanks between digits, illegal an, then wrap the frame counter.
    scan(0, 2, 1'b1);
    hold(0, 4'b1100, 7'b1000000, 2, K_SEQ, lastFrame1, cnt1);
    hold(0, 4'b1111, 7'b1111111, 2, K_NONE, 16'h0, 8'h0);
    for (int n = 0; n < 255; n++) scan(0, 1, 1'b0);

    repeat (10) @(posedge clk);
    #1;
    checkVal("wrap_count1", {24'd0, bus1.frame_count}, 32'd0);
    checkVal("q1_drained", q1.size(), 32'd0);
    checkVal("q3_drained", q3.size(), 32'd0);
    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
